// File: rtl/traffic_pkg.sv
// traffic_pkg: shared lamp/driver types and RGB bit positions for the traffic lamp LED driver
package traffic_pkg;
  typedef enum logic [2:0] {DARK, RED, RED_ORANGE, ORANGE, GREEN, ILLEGAL} lamp_e;
  typedef enum logic {NORMAL, FAULT} drv_state_e;
  localparam int RED_BIT = 0;
  localparam int GREEN_BIT = 1;
  localparam int BLUE_BIT = 2;
  function automatic lamp_e decode(input logic [2:0] rog);
    case (rog)
      3'b000:  return DARK;
      3'b100:  return RED;
      3'b110:  return RED_ORANGE;
      3'b010:  return ORANGE;
      3'b001:  return GREEN;
      default: return ILLEGAL;
    endcase
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for one asynchronous bit, resets to 0
module sync_2ff (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) {q, meta} <= 2'b00;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/traffic_lamp_rgb_driver.sv
// traffic_lamp_rgb_driver: lamp commands -> PWM RGB LED, with latched flashing-red fault mode
module traffic_lamp_rgb_driver
  import traffic_pkg::*;
#(
  parameter int PWM_WIDTH         = 8,
  parameter int RED_DUTY          = 255,
  parameter int GREEN_DUTY        = 255,
  parameter int ORANGE_GREEN_DUTY = 96,
  parameter int FAULT_HOLD        = 1024,
  parameter int FLASH_HALF        = 50000000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       red_in,
  input  logic       orange_in,
  input  logic       green_in,
  input  logic       clear_fault,
  output logic [2:0] rgb,
  output logic       fault
);
  localparam int W  = PWM_WIDTH;
  localparam int HW = $clog2(FAULT_HOLD + 1);
  localparam int FW = $clog2(FLASH_HALF + 1);
  localparam logic [W-1:0]  CNT_MAX   = W'(2**W - 2);
  localparam logic [W-1:0]  RD        = W'(RED_DUTY);
  localparam logic [W-1:0]  GD        = W'(GREEN_DUTY);
  localparam logic [W-1:0]  OGD       = W'(ORANGE_GREEN_DUTY);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(FAULT_HOLD - 1);
  localparam logic [FW-1:0] FLASH_MAX = FW'(FLASH_HALF - 1);

  logic r_s, o_s, g_s, illegal, cnt0, exiting, pwm_on;
  lamp_e lamp;
  drv_state_e state, state_n;
  logic [W-1:0] cnt, tgt_r, tgt_g, tgt_r_n, tgt_g_n, lat_r, lat_g, eff_r, eff_g;
  logic [HW-1:0] hold, hold_n;
  logic [FW-1:0] fcnt, fcnt_n;
  logic phase, phase_n, blank, blank_n, fault_n;
  logic [2:0] rgb_n;

  sync_2ff u_sync_r (.clk(clk), .rstn(rstn), .d(red_in),    .q(r_s));
  sync_2ff u_sync_o (.clk(clk), .rstn(rstn), .d(orange_in), .q(o_s));
  sync_2ff u_sync_g (.clk(clk), .rstn(rstn), .d(green_in),  .q(g_s));

  // Targets remember the last legal colour; the PWM picks them up only at cnt==0.
  always_comb begin
    lamp    = decode({r_s, o_s, g_s});
    illegal = lamp == ILLEGAL;
    cnt0    = cnt == '0;
    tgt_r_n = illegal ? tgt_r : (lamp inside {RED, RED_ORANGE, ORANGE}) ? RD : '0;
    tgt_g_n = illegal ? tgt_g : lamp == GREEN ? GD : (lamp inside {RED_ORANGE, ORANGE}) ? OGD : '0;
    eff_r   = cnt0 ? tgt_r_n : lat_r;
    eff_g   = cnt0 ? tgt_g_n : lat_g;
  end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= NORMAL;
    else state <= state_n;

  always_comb
    state_n = state == NORMAL ? ((illegal && hold == HOLD_MAX) ? FAULT : NORMAL)
                              : ((clear_fault && !illegal) ? NORMAL : FAULT);

  // After a clear, output stays dark until the PWM period restarts.
  always_comb begin
    exiting         = state == FAULT && state_n == NORMAL;
    hold_n          = (state == NORMAL && illegal) ? hold + 1'b1 : '0;
    fcnt_n          = (state != FAULT || fcnt == FLASH_MAX) ? '0 : fcnt + 1'b1;
    phase_n         = state == FAULT && (fcnt == FLASH_MAX ? !phase : phase);
    blank_n         = exiting || (blank && !cnt0);
    pwm_on          = state_n == NORMAL && !blank_n;
    rgb_n[RED_BIT]   = state_n == FAULT ? phase_n : pwm_on && cnt < eff_r;
    rgb_n[GREEN_BIT] = pwm_on && cnt < eff_g;
    rgb_n[BLUE_BIT]  = 1'b0;
    fault_n         = state_n == FAULT;
  end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      cnt   <= '0;
      tgt_r <= '0;
      tgt_g <= '0;
      lat_r <= '0;
      lat_g <= '0;
      hold  <= '0;
      fcnt  <= '0;
      phase <= 1'b0;
      blank <= 1'b0;
      rgb   <= 3'b000;
      fault <= 1'b0;
    end else begin
      cnt   <= cnt == CNT_MAX ? '0 : cnt + 1'b1;
      tgt_r <= tgt_r_n;
      tgt_g <= tgt_g_n;
      if (cnt0) {lat_r, lat_g} <= {tgt_r_n, tgt_g_n};
      hold  <= hold_n;
      fcnt  <= fcnt_n;
      phase <= phase_n;
      blank <= blank_n;
      rgb   <= rgb_n;
      fault <= fault_n;
    end
endmodule

// File: tb/tb_traffic_lamp_rgb_driver.sv
// tb_traffic_lamp_rgb_driver: scenario tasks plus randomized run against a cycle-level reference model
module tb_traffic_lamp_rgb_driver;
  logic clk = 0, rstn = 0, r = 0, o = 0, g = 0, clr = 0;
  logic [2:0] rgb;
  logic fault;
  int total = 0, bad = 0;

  int n, m_hold, m_flash, tr, tg, lr, lg;
  bit m_fault, m_blank;
  logic [2:0] d1, d2, exp_rgb;
  logic exp_fault;

  always #5 clk = ~clk;

  traffic_lamp_rgb_driver #(
    .PWM_WIDTH(4), .RED_DUTY(15), .GREEN_DUTY(15), .ORANGE_GREEN_DUTY(6),
    .FAULT_HOLD(8), .FLASH_HALF(20)
  ) dut (
    .clk(clk), .rstn(rstn), .red_in(r), .orange_in(o), .green_in(g),
    .clear_fault(clr), .rgb(rgb), .fault(fault)
  );

  task automatic model_reset();
    n = 0; d1 = 0; d2 = 0; m_hold = 0; m_flash = 0; m_fault = 0; m_blank = 0;
    tr = 0; tg = 0; lr = 0; lg = 0; exp_rgb = 0; exp_fault = 0;
  endtask

  // Edge k: PWM position k mod 15, decode sees the inputs sampled two edges earlier.
  task automatic model_edge();
    logic [2:0] dec;
    int c;
    bit legal, exiting;
    dec = d2;
    c = n % 15;
    legal = !(dec == 3'b011 || dec == 3'b101 || dec == 3'b111);
    exiting = 0;
    d2 = d1;
    d1 = {r, o, g};
    if (legal) begin
      tr = (dec[2] || dec[1]) ? 15 : 0;
      tg = dec == 3'b001 ? 15 : dec[1] ? 6 : 0;
    end
    if (c == 0) begin lr = tr; lg = tg; end
    if (!m_fault) begin
      if (!legal && m_hold == 7) begin m_fault = 1; m_flash = 0; m_hold = 0; end
      else m_hold = legal ? 0 : m_hold + 1;
    end else if (clr && legal) begin
      m_fault = 0; exiting = 1;
    end else m_flash++;
    if (m_fault) exp_rgb = {2'b00, ((m_flash / 20) % 2) == 1};
    else if (exiting) begin exp_rgb = 0; m_blank = 1; end
    else if (m_blank && c != 0) exp_rgb = 0;
    else begin m_blank = 0; exp_rgb = {1'b0, c < lg, c < lr}; end
    exp_fault = m_fault;
    n++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input logic [2:0] v);
    {r, o, g} = v;
  endtask

  task automatic test_reset();
    rstn = 0;
    drive(3'b100);
    repeat (3) @(negedge clk);
    total++;
    if (rgb !== 3'b000 || fault !== 1'b0) begin
      bad++; $display("FAIL reset_hold rgb=%b fault=%b expected rgb=000 fault=0", rgb, fault);
    end
    rstn = 1;
    model_reset();
    for (int i = 0; i < 18; i++) begin
      step();
      total++;
      if (rgb !== exp_rgb || fault !== exp_fault) begin
        bad++; $display("FAIL reset_red cyc=%0d rgb=%b fault=%b expected rgb=%b fault=%b", i, rgb, fault, exp_rgb, exp_fault);
      end
    end
    for (int i = 0; i < 15; i++) begin
      step();
      total++;
      if (rgb !== 3'b001 || fault !== 1'b0) begin
        bad++; $display("FAIL red_steady cyc=%0d rgb=%b fault=%b expected rgb=001 fault=0", i, rgb, fault);
      end
    end
  endtask

  task automatic test_orange();
    int rc, gc;
    drive(3'b010);
    for (int i = 0; i < 30; i++) begin
      step();
      total++;
      if (rgb !== exp_rgb || fault !== exp_fault) begin
        bad++; $display("FAIL orange_model cyc=%0d rgb=%b fault=%b expected rgb=%b fault=%b", i, rgb, fault, exp_rgb, exp_fault);
      end
    end
    rc = 0; gc = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      rc += int'(rgb[0]);
      gc += int'(rgb[1]);
    end
    total++;
    if (rc != 15 || gc != 6) begin
      bad++; $display("FAIL orange_duty red_high=%0d green_high=%0d expected 15 and 6", rc, gc);
    end
  endtask

  task automatic test_glitch();
    drive(3'b101);
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (fault !== 1'b0 || rgb !== exp_rgb) begin
        bad++; $display("FAIL glitch_hold cyc=%0d rgb=%b fault=%b expected rgb=%b fault=0", i, rgb, fault, exp_rgb);
      end
    end
    drive(3'b001);
    for (int i = 0; i < 30; i++) begin
      step();
      total++;
      if (rgb !== exp_rgb || fault !== exp_fault) begin
        bad++; $display("FAIL glitch_green cyc=%0d rgb=%b fault=%b expected rgb=%b fault=%b", i, rgb, fault, exp_rgb, exp_fault);
      end
    end
    total++;
    if (rgb !== 3'b010 || fault !== 1'b0) begin
      bad++; $display("FAIL green_steady rgb=%b fault=%b expected rgb=010 fault=0", rgb, fault);
    end
  endtask

  task automatic test_fault_entry();
    logic [2:0] want;
    drive(3'b111);
    for (int i = 0; i < 9; i++) begin
      step();
      total++;
      if (fault !== 1'b0) begin
        bad++; $display("FAIL fault_early cyc=%0d fault=%b expected 0", i, fault);
      end
    end
    for (int k = 0; k < 60; k++) begin
      step();
      want = {2'b00, ((k / 20) % 2) == 1};
      total++;
      if (rgb !== want || fault !== 1'b1) begin
        bad++; $display("FAIL fault_flash k=%0d rgb=%b fault=%b expected rgb=%b fault=1", k, rgb, fault, want);
      end
    end
  endtask

  task automatic test_fault_clear();
    clr = 1;
    step();
    clr = 0;
    total++;
    if (fault !== 1'b1 || rgb !== exp_rgb) begin
      bad++; $display("FAIL clear_ignored rgb=%b fault=%b expected rgb=%b fault=1", rgb, fault, exp_rgb);
    end
    drive(3'b100);
    repeat (3) step();
    total++;
    if (fault !== 1'b1) begin
      bad++; $display("FAIL sticky_fault fault=%b expected 1", fault);
    end
    clr = 1;
    step();
    clr = 0;
    total++;
    if (fault !== 1'b0 || rgb !== 3'b000) begin
      bad++; $display("FAIL clear_accept rgb=%b fault=%b expected rgb=000 fault=0", rgb, fault);
    end
    for (int i = 0; i < 30; i++) begin
      step();
      total++;
      if (rgb !== exp_rgb || fault !== exp_fault) begin
        bad++; $display("FAIL clear_resume cyc=%0d rgb=%b fault=%b expected rgb=%b fault=%b", i, rgb, fault, exp_rgb, exp_fault);
      end
    end
  endtask

  task automatic test_async_reset();
    drive(3'b111);
    repeat (12) step();
    total++;
    if (fault !== 1'b1) begin
      bad++; $display("FAIL refault fault=%b expected 1", fault);
    end
    #2 rstn = 0;
    #1;
    total++;
    if (rgb !== 3'b000 || fault !== 1'b0) begin
      bad++; $display("FAIL async_reset rgb=%b fault=%b expected rgb=000 fault=0", rgb, fault);
    end
    @(negedge clk);
    rstn = 1;
    model_reset();
    for (int i = 0; i < 12; i++) begin
      step();
      total++;
      if (rgb !== exp_rgb || fault !== exp_fault) begin
        bad++; $display("FAIL post_reset cyc=%0d rgb=%b fault=%b expected rgb=%b fault=%b", i, rgb, fault, exp_rgb, exp_fault);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] legal_v[5];
    logic [2:0] illegal_v[3];
    int left;
    legal_v = '{3'b000, 3'b100, 3'b110, 3'b010, 3'b001};
    illegal_v = '{3'b011, 3'b101, 3'b111};
    left = 0;
    for (int i = 0; i < 2000; i++) begin
      if (left == 0) begin
        drive($urandom_range(0, 9) < 7 ? legal_v[$urandom_range(0, 4)] : illegal_v[$urandom_range(0, 2)]);
        left = $urandom_range(1, 20);
      end
      left--;
      clr = $urandom_range(0, 15) == 0;
      step();
      total++;
      if (rgb !== exp_rgb || fault !== exp_fault) begin
        bad++; $display("FAIL random cyc=%0d in=%b rgb=%b fault=%b expected rgb=%b fault=%b", i, {r, o, g}, rgb, fault, exp_rgb, exp_fault);
      end
    end
    clr = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_orange();
    test_glitch();
    test_fault_entry();
    test_fault_clear();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/traffic_lamp_rgb_driver.md
Name: traffic_lamp_rgb_driver

Overview:
- Downstream stage of the traffic light controller. Consumes its red/orange/green lamp commands and drives one on-board RGB LED.
- Commands are synchronised into the fast board clock, decoded to a colour, and rendered with per-channel PWM (orange = red + dimmed green).
- Illegal lamp combinations that persist force a latched flashing-red fault mode.

Parameters:
- PWM_WIDTH, 8, PWM counter width; PWM period = 2**PWM_WIDTH-1 clocks.
- RED_DUTY, 255, red-channel duty for red, orange and red+orange colours.
- GREEN_DUTY, 255, green-channel duty for the green colour.
- ORANGE_GREEN_DUTY, 96, green-channel duty mixed in for the orange and red+orange colours.
- FAULT_HOLD, 1024, consecutive clocks an illegal combination must persist before a fault is latched.
- FLASH_HALF, 50000000, clocks per half-period of the fault flash (0.5 s at 100 MHz).

Ports:
- clk  input  1  board clock (100 MHz).
- rstn  input  1  asynchronous active-low reset.
- red_in  input  1  red lamp command from the traffic light; asynchronous to clk.
- orange_in  input  1  orange lamp command; asynchronous to clk.
- green_in  input  1  green lamp command; asynchronous to clk.
- clear_fault  input  1  synchronous single-cycle request to leave fault mode.
- rgb  output  3  LED drive: bit0 red, bit1 green, bit2 blue. Active high, registered.
- fault  output  1  high while in fault mode. Registered.

Behaviour:
- Reset (rstn=0, asynchronous): rgb=3'b000, fault=0, synchronisers=0, PWM counter=0, latched duties=0, hold counter=0, flash counter=0, flash phase=0, state NORMAL.
- Synchronisation: each of red_in/orange_in/green_in passes through its own 2-flop synchroniser. Decode uses the synchronised vector {r,o,g}.
- Decode:
  - 000 DARK: duties R=0, G=0.
  - 100 RED: R=RED_DUTY, G=0.
  - 110 RED_ORANGE: R=RED_DUTY, G=ORANGE_GREEN_DUTY.
  - 010 ORANGE: R=RED_DUTY, G=ORANGE_GREEN_DUTY.
  - 001 GREEN: R=0, G=GREEN_DUTY.
  - 011, 101, 111: ILLEGAL; duties hold their previous values.
- PWM:
  - Free-running counter cnt counts 0..2**PWM_WIDTH-2 and wraps to 0.
  - Duties are latched only when cnt==0, so there are no mid-period glitches.
  - Channel output is 1 when cnt < latched duty, registered into rgb. Duty 255 (W=8) gives a constant 1; duty 0 gives a constant 0.
  - rgb[2] is always 0.
- Latency: input edge to synchronised decode is 2 clocks. A colour change appears in rgb at the next cnt==0, plus 1 clock; the worst case is 2+255+1 clocks.
- FSM NORMAL:
  - The hold counter increments each clock the decode is ILLEGAL and clears to 0 on any legal decode.
  - When the hold counter reaches FAULT_HOLD-1 while still ILLEGAL, move to FAULT on the next edge.
  - Transient combinations during input skew therefore never fault.
- FSM FAULT:
  - fault=1. PWM duties are ignored.
  - rgb = {1'b0, 1'b0, flash_phase}. flash_phase toggles every FLASH_HALF clocks; the flash counter and phase are reset to 0 on FAULT entry, so red starts off for one half-period.
  - Exit to NORMAL only when clear_fault=1 and the current decode is legal. The hold counter is zeroed on exit.
  - clear_fault while the decode is ILLEGAL is ignored. clear_fault in NORMAL is ignored.
- Fault is sticky across legal inputs; only clear_fault or rstn leaves it.
- rstn asserted mid-flash or mid-PWM-period returns every register to its reset value immediately.
- Simultaneous events:
  - If the hold threshold and a legal decode occur on the same clock, the legal decode wins (no fault).
  - On the clock a clear is accepted, flash rendering stops and the PWM outputs resume at the next cnt==0. Until then rgb=000.

Decomposition:
- Shared package traffic_pkg:
  - lamp_e enum: DARK, RED, RED_ORANGE, ORANGE, GREEN, ILLEGAL.
  - drv_state_e enum: NORMAL, FAULT.
  - Localparam for the RGB bit indices (RED_BIT=0, GREEN_BIT=1, BLUE_BIT=2).
- Sub-module sync_2ff: one-bit, clk/rstn, reset value 0, instantiated three times. Reusable for BTN inputs.

Test Plan:
- Bench overrides: PWM_WIDTH=4, FAULT_HOLD=8, FLASH_HALF=20.
- Reset/dark: rstn low with inputs 100 -> rgb=000, fault=0. Release rstn, hold red_in=1 -> rgb[0] constantly 1 from at most 2+15+1 clocks later; rgb[1]=0 throughout.
- Orange mix: RED_DUTY=15, ORANGE_GREEN_DUTY=6, inputs 010 -> in every 15-clock period rgb[0] is high 15 clocks and rgb[1] is high exactly 6 clocks, starting at cnt==0.
- Glitch immunity: drive 101 for 5 clocks, then 001 -> fault stays 0. Green appears after the next cnt==0; no flashing.
- Fault entry: hold 111 for 8+2 clocks -> fault=1. rgb[0] is 0 for 20 clocks, then 1 for 20 clocks, repeating; rgb[2:1]=00.
- Fault clear: pulse clear_fault during 111 -> fault stays 1. Set 100, pulse clear_fault -> fault=0 on the next clock, and rgb[0] resumes PWM at the next cnt==0.
- Async reset mid-fault: assert rstn=0 between clock edges -> rgb=000 and fault=0 immediately. After release, the state is NORMAL with hold counter 0.
